// File: rtl/cache_nwsa.sv
// N-way set-associative write-back/write-allocate cache controller with true-LRU
// age counters, burst line fill/write-back and a whole-cache flush scan.
module cache_nwsa #(
  parameter int AWIDTH    = 16,
  parameter int DWIDTH    = 8,
  parameter int WAYS      = 4,
  parameter int SETS      = 8,
  parameter int BLOCKSIZE = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [AWIDTH-1:0] addr_cpu,
  input  logic [DWIDTH-1:0] wdata_cpu,
  input  logic              rd_cpu,
  input  logic              wr_cpu,
  input  logic              flush_cpu,
  output logic [DWIDTH-1:0] rdata_cpu,
  output logic              ack_cpu,
  output logic              stall_cpu,
  output logic [AWIDTH-1:0] addr_mem,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [DWIDTH-1:0] wdata_mem,
  input  logic [DWIDTH-1:0] rdata_mem,
  input  logic              ready_mem,
  input  logic              valid_mem
);
  localparam int OFFW = $clog2(BLOCKSIZE);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = AWIDTH - IDXW - OFFW;
  localparam int AGEW = $clog2(WAYS);
  localparam int CNTW = IDXW + AGEW;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, FLUSH} state_t;
  typedef logic [WAYS-1:0][AGEW-1:0] ages_t;

  state_t state_q, state_d;
  logic [SETS-1:0][WAYS-1:0]                          valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0][WAYS-1:0][TAGW-1:0]                tag_q, tag_d;
  logic [SETS-1:0][WAYS-1:0][AGEW-1:0]                age_q, age_d;
  logic [SETS-1:0][WAYS-1:0][BLOCKSIZE-1:0][DWIDTH-1:0] data_q, data_d;
  logic [AWIDTH-1:0] addr_q, addr_d, addr_mem_q, addr_mem_d;
  logic [DWIDTH-1:0] wbyte_q, wbyte_d, rdata_q, rdata_d, wdata_mem_q, wdata_mem_d;
  logic              wr_op_q, wr_op_d, flushing_q, flushing_d;
  logic              ack_q, ack_d, stall_q, stall_d, rd_mem_q, rd_mem_d, wr_mem_q, wr_mem_d;
  logic [AGEW-1:0]   vic_q, vic_d;
  logic [IDXW-1:0]   set_q, set_d;
  logic [OFFW-1:0]   k_q, k_d;
  logic [CNTW:0]     fcnt_q, fcnt_d;   // extra MSB marks "all entries scanned"

  logic [TAGW-1:0] tag;
  logic [IDXW-1:0] idx, fset;
  logic [OFFW-1:0] off;
  logic [AGEW-1:0] fway, hit_way, inv_way, old_way, vic_sel;
  logic            hit, inv_found;

  assign tag  = addr_q[AWIDTH-1 -: TAGW];
  assign idx  = addr_q[OFFW +: IDXW];
  assign off  = addr_q[OFFW-1:0];
  assign fset = fcnt_q[CNTW-1 -: IDXW];
  assign fway = fcnt_q[AGEW-1:0];

  function automatic ages_t lru_touch(input ages_t ages, input logic [AGEW-1:0] way);
    lru_touch = ages;
    for (int w = 0; w < WAYS; w++)
      if (ages[w] < ages[way]) lru_touch[w] = ages[w] + 1'b1;
    lru_touch[way] = '0;
  endfunction

  // Descending scan so the lowest-index match wins.
  always_comb begin
    hit = 1'b0; hit_way = '0; inv_found = 1'b0; inv_way = '0; old_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin hit = 1'b1; hit_way = AGEW'(w); end
      if (!valid_q[idx][w]) begin inv_found = 1'b1; inv_way = AGEW'(w); end
      if (age_q[idx][w] == AGEW'(WAYS-1)) old_way = AGEW'(w);
    end
    vic_sel = inv_found ? inv_way : old_way;
  end

  always_comb begin
    state_d = state_q; valid_d = valid_q; dirty_d = dirty_q; tag_d = tag_q; age_d = age_q;
    data_d = data_q; addr_d = addr_q; wbyte_d = wbyte_q; wr_op_d = wr_op_q;
    flushing_d = flushing_q; rdata_d = rdata_q; ack_d = 1'b0; stall_d = stall_q;
    addr_mem_d = addr_mem_q; rd_mem_d = rd_mem_q; wr_mem_d = wr_mem_q; wdata_mem_d = wdata_mem_q;
    vic_d = vic_q; set_d = set_q; k_d = k_q; fcnt_d = fcnt_q;
    case (state_q)
      IDLE: if (!ack_q) begin  // requester still holds its level in the ack cycle
        if (flush_cpu) begin
          fcnt_d = '0; flushing_d = 1'b1; stall_d = 1'b1; state_d = FLUSH;
        end else if (rd_cpu || wr_cpu) begin
          addr_d = addr_cpu; wbyte_d = wdata_cpu; wr_op_d = !rd_cpu;
          flushing_d = 1'b0; stall_d = 1'b1; state_d = LOOKUP;
        end
      end
      LOOKUP: if (hit) begin
        age_d[idx] = lru_touch(age_q[idx], hit_way);
        if (wr_op_q) begin
          data_d[idx][hit_way][off] = wbyte_q;
          dirty_d[idx][hit_way] = 1'b1;
        end else rdata_d = data_q[idx][hit_way][off];
        ack_d = 1'b1; stall_d = 1'b0; state_d = IDLE;
      end else begin
        vic_d = vic_sel; set_d = idx; k_d = '0;
        if (valid_q[idx][vic_sel] && dirty_q[idx][vic_sel]) begin
          wr_mem_d = 1'b1; wdata_mem_d = data_q[idx][vic_sel][0];
          addr_mem_d = {tag_q[idx][vic_sel], idx, {OFFW{1'b0}}};
          state_d = WRITEBACK;
        end else begin
          rd_mem_d = 1'b1; addr_mem_d = {tag, idx, {OFFW{1'b0}}}; state_d = FILL;
        end
      end
      WRITEBACK: if (ready_mem) begin
        if (k_q == OFFW'(BLOCKSIZE-1)) begin
          dirty_d[set_q][vic_q] = 1'b0; wr_mem_d = 1'b0; k_d = '0;
          if (flushing_q) state_d = FLUSH;
          else begin
            rd_mem_d = 1'b1; addr_mem_d = {tag, idx, {OFFW{1'b0}}}; state_d = FILL;
          end
        end else begin
          k_d = k_q + 1'b1;
          wdata_mem_d = data_q[set_q][vic_q][k_q + 1'b1];
        end
      end
      FILL: if (valid_mem) begin
        data_d[set_q][vic_q][k_q] = rdata_mem;
        if (k_q == OFFW'(BLOCKSIZE-1)) begin
          rd_mem_d = 1'b0; k_d = '0;
          valid_d[set_q][vic_q] = 1'b1; dirty_d[set_q][vic_q] = 1'b0; tag_d[set_q][vic_q] = tag;
          age_d[set_q] = lru_touch(age_q[set_q], vic_q);
          state_d = LOOKUP;
        end else k_d = k_q + 1'b1;
      end
      FLUSH: if (fcnt_q[CNTW]) begin
        ack_d = 1'b1; stall_d = 1'b0; state_d = IDLE;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
        if (dirty_q[fset][fway]) begin
          set_d = fset; vic_d = fway; k_d = '0;
          wr_mem_d = 1'b1; wdata_mem_d = data_q[fset][fway][0];
          addr_mem_d = {tag_q[fset][fway], fset, {OFFW{1'b0}}};
          state_d = WRITEBACK;
        end else if (fcnt_q[CNTW-1:0] == {CNTW{1'b1}}) begin
          ack_d = 1'b1; stall_d = 1'b0; state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE; valid_q <= '0; dirty_q <= '0; tag_q <= '0; data_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGEW'(w);
      addr_q <= '0; wbyte_q <= '0; wr_op_q <= 1'b0; flushing_q <= 1'b0;
      rdata_q <= '0; ack_q <= 1'b0; stall_q <= 1'b0;
      addr_mem_q <= '0; rd_mem_q <= 1'b0; wr_mem_q <= 1'b0; wdata_mem_q <= '0;
      vic_q <= '0; set_q <= '0; k_q <= '0; fcnt_q <= '0;
    end else begin
      state_q <= state_d; valid_q <= valid_d; dirty_q <= dirty_d; tag_q <= tag_d;
      age_q <= age_d; data_q <= data_d;
      addr_q <= addr_d; wbyte_q <= wbyte_d; wr_op_q <= wr_op_d; flushing_q <= flushing_d;
      rdata_q <= rdata_d; ack_q <= ack_d; stall_q <= stall_d;
      addr_mem_q <= addr_mem_d; rd_mem_q <= rd_mem_d; wr_mem_q <= wr_mem_d; wdata_mem_q <= wdata_mem_d;
      vic_q <= vic_d; set_q <= set_d; k_q <= k_d; fcnt_q <= fcnt_d;
    end
  end

  assign rdata_cpu = rdata_q;
  assign ack_cpu   = ack_q;
  assign stall_cpu = stall_q;
  assign addr_mem  = addr_mem_q;
  assign rd_mem    = rd_mem_q;
  assign wr_mem    = wr_mem_q;
  assign wdata_mem = wdata_mem_q;
endmodule

// File: tb/tb_cache_nwsa.sv
// Directed bench for cache_nwsa: byte-addressed memory responder plus CPU request tasks.
module tb_cache_nwsa;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic [15:0] addr_cpu = '0, addr_mem;
  logic [7:0]  wdata_cpu = '0, rdata_cpu, wdata_mem, rdata_mem = '0;
  logic        rd_cpu = 1'b0, wr_cpu = 1'b0, flush_cpu = 1'b0;
  logic        ack_cpu, stall_cpu, rd_mem, wr_mem;
  logic        ready_mem = 1'b1, valid_mem = 1'b0;

  cache_nwsa dut (
    .clock(clock), .reset_n(reset_n), .addr_cpu(addr_cpu), .wdata_cpu(wdata_cpu),
    .rd_cpu(rd_cpu), .wr_cpu(wr_cpu), .flush_cpu(flush_cpu), .rdata_cpu(rdata_cpu),
    .ack_cpu(ack_cpu), .stall_cpu(stall_cpu), .addr_mem(addr_mem), .rd_mem(rd_mem),
    .wr_mem(wr_mem), .wdata_mem(wdata_mem), .rdata_mem(rdata_mem), .ready_mem(ready_mem),
    .valid_mem(valid_mem));

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  mem [0:65535];
  logic [15:0] wb_addr [0:63];
  logic [7:0]  wb_data [0:63];
  int fb = 0, wb_n = 0, rd_cyc = 0;
  int gap_beat = -1, gap_left = 0;
  logic [7:0] gap_exp = '0;

  // Memory side: fill beats, write-back acceptance and capture, all driven on negedge.
  always @(negedge clock) begin
    if (rd_mem) begin
      rd_cyc++;
      rdata_mem = mem[addr_mem + 16'(fb)]; valid_mem = 1'b1; fb++;
    end else begin
      valid_mem = 1'b0; fb = 0;
    end
    if (wr_mem && gap_left > 0 && (wb_n % 4) == gap_beat) begin
      ready_mem = 1'b0; gap_left--;
      chk("wb_hold_data", 32'(wdata_mem), 32'(gap_exp));
    end else ready_mem = 1'b1;
    if (wr_mem && ready_mem && wb_n < 64) begin
      wb_addr[wb_n] = addr_mem; wb_data[wb_n] = wdata_mem;
      mem[addr_mem + 16'(wb_n % 4)] = wdata_mem;
      wb_n++;
    end
  end

  // op: 0 read, 1 write, 2 flush
  task automatic cpu(input int op, input logic [15:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output int cyc);
    @(negedge clock);
    addr_cpu = a; wdata_cpu = d;
    rd_cpu = (op == 0); wr_cpu = (op == 1); flush_cpu = (op == 2);
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (!ack_cpu && cyc < 400);
    chk("ack_seen", 32'(ack_cpu), 1);
    chk("stall_low_at_ack", 32'(stall_cpu), 0);
    rd = rdata_cpu;
    rd_cpu = 1'b0; wr_cpu = 1'b0; flush_cpu = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; rd_cpu = 1'b0; wr_cpu = 1'b0; flush_cpu = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_ack", 32'(ack_cpu), 0);
    chk("rst_stall", 32'(stall_cpu), 0);
    chk("rst_rd_mem", 32'(rd_mem), 0);
    chk("rst_wr_mem", 32'(wr_mem), 0);
    chk("rst_outs", {addr_mem, rdata_cpu, wdata_mem}, 0);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] r;
    int c, rc0, wb0;
    logic [15:0] seq2 [0:3];
    logic [7:0]  wbexp [0:7];
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
    mem[16'h0040] = 8'h11; mem[16'h0041] = 8'h22; mem[16'h0042] = 8'h33; mem[16'h0043] = 8'h44;

    // Clean miss then hit on the same line
    do_reset();
    rc0 = rd_cyc;
    cpu(0, 16'h0040, 0, r, c);
    chk("t1_miss_data", 32'(r), 32'h11);
    chk("t1_miss_lat", 32'(c), 7);
    chk("t1_fill_beats", 32'(rd_cyc - rc0), 4);
    rc0 = rd_cyc;
    cpu(0, 16'h0043, 0, r, c);
    chk("t1_hit_data", 32'(r), 32'h44);
    chk("t1_hit_lat", 32'(c), 2);
    chk("t1_hit_no_rd_mem", 32'(rd_cyc - rc0), 0);

    // LRU victim choice in set 0
    do_reset();
    seq2[0] = 16'h0000; seq2[1] = 16'h0020; seq2[2] = 16'h0040; seq2[3] = 16'h0060;
    for (int i = 0; i < 4; i++) begin
      cpu(0, seq2[i], 0, r, c);
      chk("t2_fill_lat", 32'(c), 7);
    end
    cpu(0, 16'h0000, 0, r, c); chk("t2_hit0_lat", 32'(c), 2); chk("t2_hit0_data", 32'(r), 0);
    cpu(0, 16'h0080, 0, r, c); chk("t2_evict_lat", 32'(c), 7); chk("t2_evict_data", 32'(r), 32'h80);
    cpu(0, 16'h0000, 0, r, c); chk("t2_keep0_lat", 32'(c), 2);
    cpu(0, 16'h0040, 0, r, c); chk("t2_keep40_lat", 32'(c), 2);
    cpu(0, 16'h0060, 0, r, c); chk("t2_keep60_lat", 32'(c), 2);
    cpu(0, 16'h0020, 0, r, c); chk("t2_gone20_lat", 32'(c), 7);

    // Dirty eviction with a 3-cycle ready_mem gap on beat 1
    do_reset();
    cpu(1, 16'h0001, 8'hA5, r, c); chk("t3_wmiss_lat", 32'(c), 7);
    for (int i = 1; i < 4; i++) cpu(0, seq2[i], 0, r, c);
    wb0 = wb_n; gap_beat = 1; gap_left = 3; gap_exp = 8'hA5;
    cpu(0, 16'h0080, 0, r, c);
    chk("t3_dirty_lat", 32'(c), 14);
    chk("t3_dirty_data", 32'(r), 32'h80);
    chk("t3_wb_beats", 32'(wb_n - wb0), 4);
    chk("t3_gap_used", 32'(gap_left), 0);
    gap_beat = -1;
    wbexp[0] = 8'h00; wbexp[1] = 8'hA5; wbexp[2] = 8'h02; wbexp[3] = 8'h03;
    for (int i = 0; i < 4; i++) begin
      chk("t3_wb_addr", 32'(wb_addr[wb0+i]), 32'h0000);
      chk("t3_wb_data", 32'(wb_data[wb0+i]), 32'(wbexp[i]));
    end
    cpu(0, 16'h0001, 0, r, c);
    chk("t3_reload_data", 32'(r), 32'hA5);

    // Flush with dirty lines in sets 2 and 7
    do_reset();
    cpu(1, 16'h0008, 8'h77, r, c);
    cpu(1, 16'h001D, 8'h99, r, c);
    wb0 = wb_n;
    cpu(2, 16'h0000, 0, r, c);
    chk("t5_flush_lat", 32'(c), 41);
    chk("t5_wb_beats", 32'(wb_n - wb0), 8);
    wbexp[0] = 8'h77; wbexp[1] = 8'h09; wbexp[2] = 8'h0A; wbexp[3] = 8'h0B;
    wbexp[4] = 8'h1C; wbexp[5] = 8'h99; wbexp[6] = 8'h1E; wbexp[7] = 8'h1F;
    for (int i = 0; i < 8; i++) begin
      chk("t5_wb_addr", 32'(wb_addr[wb0+i]), (i < 4) ? 32'h0008 : 32'h001C);
      chk("t5_wb_data", 32'(wb_data[wb0+i]), 32'(wbexp[i]));
    end
    wb0 = wb_n;
    cpu(2, 16'h0000, 0, r, c);
    chk("t5_flush2_lat", 32'(c), 33);
    chk("t5_flush2_no_wb", 32'(wb_n - wb0), 0);
    cpu(0, 16'h0009, 0, r, c);
    chk("t5_still_valid_lat", 32'(c), 2);
    chk("t5_still_valid_data", 32'(r), 32'h09);

    // Reset in the middle of a fill
    @(negedge clock);
    addr_cpu = 16'h0040; rd_cpu = 1'b1;
    c = 0;
    while (!rd_mem && c < 50) begin @(negedge clock); c++; end
    chk("t6_fill_started", 32'(rd_mem), 1);
    repeat (2) @(negedge clock);
    reset_n = 1'b0; rd_cpu = 1'b0;
    #1;
    chk("t6_rst_rd_mem", 32'(rd_mem), 0);
    chk("t6_rst_stall", 32'(stall_cpu), 0);
    chk("t6_rst_ack", 32'(ack_cpu), 0);
    @(negedge clock); reset_n = 1'b1;
    rc0 = rd_cyc;
    cpu(0, 16'h0040, 0, r, c);
    chk("t6_remiss_lat", 32'(c), 7);
    chk("t6_remiss_beats", 32'(rd_cyc - rc0), 4);
    chk("t6_remiss_data", 32'(r), 32'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cache_nwsa.md
# cache_nwsa

Parametrised N-way set-associative write-back, write-allocate cache controller between the CPU and the main-memory controller, successor to the fixed 2-way design. Ways, sets, line size and widths are parameters. True-LRU replacement uses per-way age counters. Adds a burst memory handshake and a whole-cache flush command. Tag, state and data storage are internal register arrays, so no external RAM macros are needed.

## Interface
- AWIDTH, 16, address width (byte address)
- DWIDTH, 8, data width of CPU and memory beats
- WAYS, 4, associativity (power of 2, ≥2)
- SETS, 8, number of sets (power of 2)
- BLOCKSIZE, 4, bytes (beats) per line (power of 2)
- Derived: OFFW=log2(BLOCKSIZE), IDXW=log2(SETS), TAGW=AWIDTH-IDXW-OFFW, AGEW=log2(WAYS)

Ports:
- clock  in  1  single clock for CPU side and memory side
- reset_n  in  1  asynchronous, active-low reset
- addr_cpu  in  AWIDTH  CPU byte address; address = {tag, index, offset}
- wdata_cpu  in  DWIDTH  CPU write byte
- rd_cpu  in  1  read request, level, held until ack_cpu
- wr_cpu  in  1  write request, level, held until ack_cpu
- flush_cpu  in  1  flush request, level, held until ack_cpu
- rdata_cpu  out  DWIDTH  read data, valid when ack_cpu=1 for a read
- ack_cpu  out  1  one-cycle completion pulse
- stall_cpu  out  1  high while the controller is busy (state ≠ IDLE)
- addr_mem  out  AWIDTH  line base address (offset bits = 0)
- rd_mem  out  1  line-fill request
- wr_mem  out  1  write-back beat valid
- wdata_mem  out  DWIDTH  write-back beat data
- rdata_mem  in  DWIDTH  fill beat data
- ready_mem  in  1  memory accepts a write-back beat this cycle
- valid_mem  in  1  fill beat valid on rdata_mem this cycle

## Operation
- **Per-line state:** valid, dirty, tag, age (AGEW bits), and BLOCKSIZE bytes.
- **Reset values:**
  - all valid and dirty bits are 0; age[w]=w.
  - all outputs are 0; state is IDLE.
  - reset asserted mid-burst aborts immediately, and rd_mem/wr_mem drop asynchronously.
- **States:** IDLE, LOOKUP, WRITEBACK, FILL, FLUSH.
- **IDLE:**
  - Request priority is flush_cpu > rd_cpu > wr_cpu.
  - On rd or wr, latch the address, write byte and op, then go to LOOKUP.
  - On flush, clear the set/way counter, then go to FLUSH.
- **LOOKUP:** compare the latched tag against all valid ways of the set.
  - Hit on a read: rdata_cpu = line byte at the offset, ack_cpu=1, then IDLE.
  - Hit on a write: write the byte, set dirty, ack_cpu=1, then IDLE.
  - Miss, victim = lowest-index invalid way; otherwise the way whose age = WAYS-1.
  - Miss with a valid and dirty victim: go to WRITEBACK.
  - Miss otherwise: go to FILL.
- **LRU update:** on a hit or a fill install to way w with age a:
  - every way in the set with age < a increments;
  - age[w]=0.
  - Ages within a set always stay a permutation of 0..WAYS-1.
- **WRITEBACK:**
  - addr_mem = {victim tag, index, 0}; wr_mem=1; wdata_mem = byte k, starting at k=0.
  - k advances only on a cycle where wr_mem & ready_mem.
  - After beat BLOCKSIZE-1 is accepted: clear the victim's dirty bit and drop wr_mem.
  - Next state is FILL for a miss, FLUSH for a flush.
- **FILL:**
  - addr_mem = {latched tag, index, 0}; rd_mem=1.
  - Each valid_mem cycle stores rdata_mem into victim byte k; k increments.
  - After the last beat: rd_mem=0; install the line with valid=1, dirty=0, new tag; update LRU; return to LOOKUP.
  - The replay in LOOKUP is guaranteed to hit and completes the request.
- **FLUSH:**
  - Scan sets 0..SETS-1 and, within each set, ways 0..WAYS-1, one entry per cycle.
  - A dirty entry goes to WRITEBACK and resumes at the next entry.
  - Valid bits and ages are unchanged.
  - After the last entry: ack_cpu=1, then IDLE.
- A request changing while stall_cpu=1 is ignored; the latched values are used.
- valid_mem in any state other than FILL is ignored; ready_mem outside WRITEBACK is ignored.

## Timing
- All outputs are registered.
- stall_cpu rises on the edge that accepts a request and falls on the edge where ack_cpu rises.
- Read/write hit: ack_cpu two cycles after the request is sampled (IDLE→LOOKUP→IDLE).
- Clean miss: accept edge, LOOKUP, FILL of ≥BLOCKSIZE cycles, LOOKUP, ack. Minimum latency BLOCKSIZE+3 cycles with valid_mem held high.
- A dirty miss adds ≥BLOCKSIZE WRITEBACK cycles.
- wr_mem and wdata_mem hold their value while ready_mem=0.
- Back-to-back requests: a new request may be accepted in the cycle after ack_cpu.
- Flush with no dirty lines takes SETS·WAYS+1 cycles to ack.

## Test plan
- Reset, then read 0x0040 → FILL from 0x0040 with 4 beats 11,22,33,44 → ack with rdata_cpu=0x11. A re-read of 0x0043 then hits with ack 2 cycles later and rdata_cpu=0x44, with no rd_mem.
- Fill ways 0-3 of set 0 (addresses 0x0000, 0x0020, 0x0040, 0x0060), read 0x0000 again, then read 0x0080. The victim is way 1 (the line at 0x0020); a subsequent read of 0x0000 still hits.
- Write 0xA5 to 0x0001 (miss), then force eviction of that line. WRITEBACK shows addr_mem=0x0000 and beats {b0,0xA5,b2,b3}, then the fill.
- During a dirty writeback, hold ready_mem=0 for 3 cycles mid-burst → the beat is held stable and no beat is lost or duplicated.
- Dirty lines in sets 2 and 7 with flush_cpu asserted → exactly two 4-beat writebacks to the correct bases, then ack. A second flush issues no wr_mem.
- Assert reset_n=0 mid-FILL → rd_mem, stall_cpu and ack_cpu are 0 immediately. The next read of the same address misses.
